// File: rtl/stream_range_stats_pkg.sv
// Shared types for the stream range statistics block.
// Holds the controller state encoding and its width.
package range_stats_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2
    } state_t;

endpackage

// File: rtl/stream_range_stats_if.sv
// Sample stream and result bundle of stream_range_stats.
// master drives samples and control, slave returns results.
interface stream_range_stats_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
);
    logic [WIDTH-1:0]     data_in;
    logic                 data_valid;
    logic                 go;
    logic                 finish;
    logic [WIDTH-1:0]     range;
    logic [WIDTH-1:0]     max_out;
    logic [WIDTH-1:0]     min_out;
    logic [CNT_WIDTH-1:0] count;
    logic                 done;
    logic                 busy;
    logic                 error;

    modport master (
        output data_in, data_valid, go, finish,
        input  range, max_out, min_out, count, done, busy, error
    );

    modport slave (
        input  data_in, data_valid, go, finish,
        output range, max_out, min_out, count, done, busy, error
    );
endinterface

// File: rtl/stream_range_stats_minmax_update.sv
// Running max/min update: all sample comparisons live here.
// load seeds both extremes with the sample.
module minmax_update #(
    parameter int WIDTH       = 8,
    parameter int SIGNED_MODE = 0
) (
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] cur_max,
    input  logic [WIDTH-1:0] cur_min,
    input  logic             load,
    output logic [WIDTH-1:0] new_max,
    output logic [WIDTH-1:0] new_min
);
    logic above;
    logic below;

    // Sample against current extremes, signedness chosen at build time
    always_comb begin
        if (SIGNED_MODE != 0) begin
            above = $signed(sample) > $signed(cur_max);
            below = $signed(sample) < $signed(cur_min);
        end else begin
            above = sample > cur_max;
            below = sample < cur_min;
        end
    end

    // Select the updated extremes
    always_comb begin
        new_max = cur_max;
        new_min = cur_min;
        if (load) begin
            new_max = sample;
            new_min = sample;
        end else begin
            if (above) new_max = sample;
            if (below) new_min = sample;
        end
    end
endmodule

// File: rtl/stream_range_stats.sv
// Tracks max, min, range and sample count over go..finish sequences.
// Optional counter: define RANGE_STATS_COUNT_EN, else count reads 0.
module stream_range_stats
    import range_stats_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CNT_WIDTH   = 8,
    parameter int SIGNED_MODE = 0
) (
    input logic                 clock,
    input logic                 reset,
    stream_range_stats_if.slave bus
);
    state_t           state;
    state_t           state_nxt;
    logic             go_q;
    logic             start;
    logic             fin;
    logic             upd;
    logic [WIDTH-1:0] run_max;
    logic [WIDTH-1:0] run_min;
    logic [WIDTH-1:0] new_max;
    logic [WIDTH-1:0] new_min;
    logic [WIDTH-1:0] nxt_max;
    logic [WIDTH-1:0] nxt_min;
    logic [WIDTH-1:0] range_q;
    logic [WIDTH-1:0] max_q;
    logic [WIDTH-1:0] min_q;
    logic             done_q;

    minmax_update #(
        .WIDTH       (WIDTH),
        .SIGNED_MODE (SIGNED_MODE)
    ) u_minmax (
        .sample  (bus.data_in),
        .cur_max (run_max),
        .cur_min (run_min),
        .load    (start),
        .new_max (new_max),
        .new_min (new_min)
    );

    // Next state; a fresh go edge in RUN aborts unless finish wins
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        fin       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.go && !bus.finish) begin
                    state_nxt = RUN;
                    start     = 1'b1;
                end else if (bus.finish) begin
                    state_nxt = ERROR;
                end
            end
            RUN: begin
                if (bus.finish) begin
                    state_nxt = IDLE;
                    fin       = 1'b1;
                end else if (bus.go && !go_q) begin
                    state_nxt = ERROR;
                end
            end
            ERROR: begin
                if (bus.go && !bus.finish) begin
                    state_nxt = RUN;
                    start     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Running extremes after this cycle's sample, if any
    always_comb begin
        upd     = start || (state == RUN && bus.data_valid);
        nxt_max = upd ? new_max : run_max;
        nxt_min = upd ? new_min : run_min;
    end

    // State, go history and running extremes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            go_q    <= 1'b0;
            run_max <= '0;
            run_min <= '0;
        end else begin
            state   <= state_nxt;
            go_q    <= bus.go;
            run_max <= nxt_max;
            run_min <= nxt_min;
        end
    end

    // Result registers load only on a completed sequence
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            range_q <= '0;
            max_q   <= '0;
            min_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= fin;
            if (fin) begin
                max_q   <= nxt_max;
                min_q   <= nxt_min;
                range_q <= nxt_max - nxt_min;
            end
        end
    end

`ifdef RANGE_STATS_COUNT_EN
    logic [CNT_WIDTH-1:0] run_cnt;
    logic [CNT_WIDTH-1:0] nxt_cnt;
    logic [CNT_WIDTH-1:0] cnt_q;

    // Saturating sample count, seeded with the go-cycle sample
    always_comb begin
        nxt_cnt = run_cnt;
        if (start) begin
            nxt_cnt = CNT_WIDTH'(1);
        end else if (upd && run_cnt != '1) begin
            nxt_cnt = run_cnt + CNT_WIDTH'(1);
        end
    end

    // Running and published count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_cnt <= '0;
            cnt_q   <= '0;
        end else begin
            run_cnt <= nxt_cnt;
            if (fin) cnt_q <= nxt_cnt;
        end
    end

    assign bus.count = cnt_q;
`else
    assign bus.count = '0;
`endif

    assign bus.range   = range_q;
    assign bus.max_out = max_q;
    assign bus.min_out = min_q;
    assign bus.done    = done_q;
    assign bus.busy    = (state == RUN);
    assign bus.error   = (state == ERROR);
endmodule

// File: tb/tb_stream_range_stats.sv
// Bench for stream_range_stats: unsigned, signed and 3-bit-count
// instances share one stimulus, checked against a queue model.
module tb_stream_range_stats;
    import range_stats_pkg::*;

`ifdef RANGE_STATS_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_ERR  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       data_valid = 1'b0;
    logic       go = 1'b0;
    logic       finish = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    stream_range_stats_if #(.WIDTH(8), .CNT_WIDTH(8)) if_u ();
    stream_range_stats_if #(.WIDTH(8), .CNT_WIDTH(8)) if_s ();
    stream_range_stats_if #(.WIDTH(8), .CNT_WIDTH(3)) if_c ();

    assign if_u.data_in    = data_in;
    assign if_u.data_valid = data_valid;
    assign if_u.go         = go;
    assign if_u.finish     = finish;
    assign if_s.data_in    = data_in;
    assign if_s.data_valid = data_valid;
    assign if_s.go         = go;
    assign if_s.finish     = finish;
    assign if_c.data_in    = data_in;
    assign if_c.data_valid = data_valid;
    assign if_c.go         = go;
    assign if_c.finish     = finish;

    stream_range_stats #(.WIDTH(8), .CNT_WIDTH(8), .SIGNED_MODE(0)) u_uns (
        .clock (clk), .reset (rst), .bus (if_u)
    );
    stream_range_stats #(.WIDTH(8), .CNT_WIDTH(8), .SIGNED_MODE(1)) u_sgn (
        .clock (clk), .reset (rst), .bus (if_s)
    );
    stream_range_stats #(.WIDTH(8), .CNT_WIDTH(3), .SIGNED_MODE(0)) u_c3 (
        .clock (clk), .reset (rst), .bus (if_c)
    );

    always #5 clk = ~clk;

    wire [34:0] act_u = {if_u.done, if_u.busy, if_u.error, if_u.max_out,
                         if_u.min_out, if_u.range, if_u.count};
    wire [34:0] act_s = {if_s.done, if_s.busy, if_s.error, if_s.max_out,
                         if_s.min_out, if_s.range, if_s.count};
    wire [29:0] act_c = {if_c.done, if_c.busy, if_c.error, if_c.max_out,
                         if_c.min_out, if_c.range, if_c.count};

    // Behavioural model: sequence kept as a queue of accepted samples
    int         m_state = M_IDLE;
    logic       m_prev_go = 1'b0;
    logic [7:0] seq[$];
    logic [7:0] e_umax = 8'd0, e_umin = 8'd0;
    logic [7:0] e_smax = 8'd0, e_smin = 8'd0;
    int         e_c8 = 0, e_c3 = 0;
    logic       e_done = 1'b0;

    function automatic void model_reset();
        m_state   = M_IDLE;
        m_prev_go = 1'b0;
        seq.delete();
        e_umax = 8'd0; e_umin = 8'd0;
        e_smax = 8'd0; e_smin = 8'd0;
        e_c8 = 0; e_c3 = 0;
        e_done = 1'b0;
    endfunction

    function automatic void publish();
        int n;
        n = seq.size();
        e_umax = seq[0]; e_umin = seq[0];
        e_smax = seq[0]; e_smin = seq[0];
        for (int i = 1; i < n; i++) begin
            if (seq[i] > e_umax) e_umax = seq[i];
            if (seq[i] < e_umin) e_umin = seq[i];
            if ($signed(seq[i]) > $signed(e_smax)) e_smax = seq[i];
            if ($signed(seq[i]) < $signed(e_smin)) e_smin = seq[i];
        end
        e_c8 = CNT_ON ? ((n > 255) ? 255 : n) : 0;
        e_c3 = CNT_ON ? ((n > 7) ? 7 : n) : 0;
    endfunction

    function automatic void model_step(logic [7:0] d, logic v, logic g, logic f);
        e_done = 1'b0;
        if (m_state == M_RUN) begin
            if (f) begin
                if (v) seq.push_back(d);
                publish();
                e_done  = 1'b1;
                m_state = M_IDLE;
            end else if (g && !m_prev_go) begin
                seq.delete();
                m_state = M_ERR;
            end else if (v) begin
                seq.push_back(d);
            end
        end else begin
            if (g && !f) begin
                seq.delete();
                seq.push_back(d);
                m_state = M_RUN;
            end else if (f) begin
                m_state = M_ERR;
            end
        end
        m_prev_go = g;
    endfunction

    task automatic drive(input logic [7:0] d, input logic v,
                         input logic g, input logic f);
        data_in = d; data_valid = v; go = g; finish = f;
        model_step(d, v, g, f);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (act_u !== 35'd0 || act_s !== 35'd0 || act_c !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h %h %h want 0", act_u, act_s, act_c);
        end
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        drive(8'd20, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (if_u.busy !== 1'b1 || if_u.done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy got busy=%b done=%b want 1 0", if_u.busy, if_u.done);
        end
        drive(8'd5,   1'b1, 1'b1, 1'b0);
        drive(8'd200, 1'b1, 1'b1, 1'b0);
        drive(8'd33,  1'b0, 1'b0, 1'b0);
        drive(8'd90,  1'b1, 1'b0, 1'b0);
        drive(8'd7,   1'b1, 1'b0, 1'b1);
        n_tests++;
        if (if_u.max_out !== 8'd200 || if_u.min_out !== 8'd5 || if_u.range !== 8'd195) begin
            n_fail++;
            $display("FAIL basic_result got %0d/%0d/%0d want 200/5/195",
                     if_u.max_out, if_u.min_out, if_u.range);
        end
        n_tests++;
        if (if_u.count !== (CNT_ON ? 8'd5 : 8'd0) || if_u.done !== 1'b1 || if_u.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_count got cnt=%0d done=%b busy=%b want %0d 1 0",
                     if_u.count, if_u.done, if_u.busy, CNT_ON ? 5 : 0);
        end
        drive(8'd0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (if_u.done !== 1'b0 || if_u.max_out !== 8'd200) begin
            n_fail++;
            $display("FAIL basic_pulse got done=%b max=%0d want 0 200", if_u.done, if_u.max_out);
        end
    endtask

    task automatic test_signed();
        drive(8'h80, 1'b0, 1'b1, 1'b0);
        drive(8'h7F, 1'b1, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 1'b1, 1'b1);
        n_tests++;
        if (if_s.max_out !== 8'h7F || if_s.min_out !== 8'h80 || if_s.range !== 8'hFF) begin
            n_fail++;
            $display("FAIL signed_result got %h/%h/%h want 7f/80/ff",
                     if_s.max_out, if_s.min_out, if_s.range);
        end
        n_tests++;
        if (if_u.max_out !== 8'h80 || if_u.min_out !== 8'h00 || if_u.range !== 8'h80) begin
            n_fail++;
            $display("FAIL unsigned_same got %h/%h/%h want 80/00/80",
                     if_u.max_out, if_u.min_out, if_u.range);
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_err_idle();
        drive(8'd99, 1'b1, 1'b0, 1'b1);
        n_tests++;
        if (if_u.error !== 1'b1 || if_u.done !== 1'b0 || if_s.max_out !== 8'h7F) begin
            n_fail++;
            $display("FAIL idle_finish got err=%b done=%b smax=%h want 1 0 7f",
                     if_u.error, if_u.done, if_s.max_out);
        end
        drive(8'd1, 1'b1, 1'b1, 1'b1);
        n_tests++;
        if (if_u.error !== 1'b1 || if_u.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sticky got err=%b busy=%b want 1 0", if_u.error, if_u.busy);
        end
        drive(8'd0, 1'b0, 1'b0, 1'b0);
        drive(8'd33, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (if_u.error !== 1'b0 || if_u.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL err_restart got err=%b busy=%b want 0 1", if_u.error, if_u.busy);
        end
        drive(8'd44, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (if_u.max_out !== 8'd33 || if_u.min_out !== 8'd33 ||
            if_u.count !== (CNT_ON ? 8'd1 : 8'd0)) begin
            n_fail++;
            $display("FAIL single_sample got %0d/%0d/%0d want 33/33/%0d",
                     if_u.max_out, if_u.min_out, if_u.count, CNT_ON ? 1 : 0);
        end
    endtask

    task automatic test_go_reedge();
        drive(8'd50, 1'b0, 1'b1, 1'b0);
        drive(8'd60, 1'b1, 1'b0, 1'b0);
        drive(8'd70, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (if_u.error !== 1'b1 || if_u.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL go_reedge got err=%b busy=%b want 1 0", if_u.error, if_u.busy);
        end
        drive(8'd250, 1'b1, 1'b0, 1'b1);
        n_tests++;
        if (if_u.done !== 1'b0 || if_u.max_out !== 8'd33 || if_u.error !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_keep got done=%b max=%0d err=%b want 0 33 1",
                     if_u.done, if_u.max_out, if_u.error);
        end
        drive(8'd9,  1'b0, 1'b1, 1'b0);
        drive(8'd10, 1'b1, 1'b0, 1'b0);
        drive(8'd11, 1'b1, 1'b1, 1'b1);
        n_tests++;
        if (if_u.done !== 1'b1 || if_u.max_out !== 8'd11 || if_u.min_out !== 8'd9 ||
            if_u.count !== (CNT_ON ? 8'd3 : 8'd0)) begin
            n_fail++;
            $display("FAIL edge_and_finish got done=%b %0d/%0d/%0d want 1 11/9/%0d",
                     if_u.done, if_u.max_out, if_u.min_out, if_u.count, CNT_ON ? 3 : 0);
        end
        drive(8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_count_sat();
        drive(8'h40, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            drive(8'($urandom_range(16, 240)), 1'b1, 1'b1, i == 8);
        end
        n_tests++;
        if (if_c.count !== (CNT_ON ? 3'd7 : 3'd0) || if_u.count !== (CNT_ON ? 8'd10 : 8'd0)) begin
            n_fail++;
            $display("FAIL count_sat got c3=%0d c8=%0d want %0d %0d",
                     if_c.count, if_u.count, CNT_ON ? 7 : 0, CNT_ON ? 10 : 0);
        end
        n_tests++;
        if (if_c.max_out !== e_umax || if_c.min_out !== e_umin ||
            if_c.range !== 8'(e_umax - e_umin)) begin
            n_fail++;
            $display("FAIL count_sat_vals got %0d/%0d/%0d want %0d/%0d/%0d",
                     if_c.max_out, if_c.min_out, if_c.range,
                     e_umax, e_umin, 8'(e_umax - e_umin));
        end
    endtask

    task automatic test_reset_mid();
        drive(8'd120, 1'b0, 1'b1, 1'b0);
        drive(8'd130, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (act_u !== 35'd0 || act_s !== 35'd0 || act_c !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_mid got %h %h %h want 0", act_u, act_s, act_c);
        end
        go = 1'b0;
        #1;
        rst = 1'b0;
        drive(8'd100, 1'b0, 1'b1, 1'b0);
        drive(8'd3, 1'b1, 1'b1, 1'b1);
        n_tests++;
        if (if_u.max_out !== 8'd100 || if_u.min_out !== 8'd3 || if_u.range !== 8'd97 ||
            if_u.count !== (CNT_ON ? 8'd2 : 8'd0) || if_u.done !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_clean got %0d/%0d/%0d/%0d done=%b want 100/3/97/%0d 1",
                     if_u.max_out, if_u.min_out, if_u.range, if_u.count, if_u.done,
                     CNT_ON ? 2 : 0);
        end
    endtask

    task automatic test_random();
        logic [34:0] exp_u;
        logic [34:0] exp_s;
        logic [29:0] exp_c;
        logic [7:0]  d;
        logic        v, g, f;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0: d = 8'h00;
                1: d = 8'hFF;
                2: d = 8'h80;
                3: d = 8'h7F;
                default: d = 8'($urandom);
            endcase
            v = ($urandom_range(0, 3) != 0);
            if (m_state == M_RUN) begin
                g = ($urandom_range(0, 24) == 0) ? ~go : go;
                f = ($urandom_range(0, 11) == 0);
            end else begin
                g = ($urandom_range(0, 2) == 0);
                f = ($urandom_range(0, 7) == 0);
            end
            drive(d, v, g, f);
            exp_u = {e_done, m_state == M_RUN, m_state == M_ERR,
                     e_umax, e_umin, 8'(e_umax - e_umin), 8'(e_c8)};
            exp_s = {e_done, m_state == M_RUN, m_state == M_ERR,
                     e_smax, e_smin, 8'(e_smax - e_smin), 8'(e_c8)};
            exp_c = {e_done, m_state == M_RUN, m_state == M_ERR,
                     e_umax, e_umin, 8'(e_umax - e_umin), 3'(e_c3)};
            n_tests++;
            if (act_u !== exp_u) begin
                n_fail++;
                $display("FAIL rand_uns cyc %0d got %h want %h", i, act_u, exp_u);
            end
            n_tests++;
            if (act_s !== exp_s) begin
                n_fail++;
                $display("FAIL rand_sgn cyc %0d got %h want %h", i, act_s, exp_s);
            end
            n_tests++;
            if (act_c !== exp_c) begin
                n_fail++;
                $display("FAIL rand_c3 cyc %0d got %h want %h", i, act_c, exp_c);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_signed();
        test_err_idle();
        test_go_reedge();
        test_count_sat();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_range_stats.md
STREAM_RANGE_STATS -- requirements
Module: stream_range_stats

Interface
REQ-001 SHALL have parameter WIDTH, default 8, sample width in bits (≥2).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, sample-counter width in bits.
REQ-003 SHALL have parameter SIGNED_MODE, default 0, 0 = unsigned compare, 1 = two's-complement compare.
REQ-004 SHALL have port clock  input  1  sole clock; all state on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port data_in  input  WIDTH  sample value.
REQ-007 SHALL have port data_valid  input  1  data_in is a sample this cycle (RUN only).
REQ-008 SHALL have port go  input  1  start of sequence; data_in on the go cycle is the first sample.
REQ-009 SHALL have port finish  input  1  end of sequence.
REQ-010 SHALL have port range  output  WIDTH  unsigned max-min of the last completed sequence.
REQ-011 SHALL have port max_out  output  WIDTH  maximum of the last completed sequence.
REQ-012 SHALL have port min_out  output  WIDTH  minimum of the last completed sequence.
REQ-013 SHALL have port count  output  CNT_WIDTH  samples in the last completed sequence.
REQ-014 SHALL have port done  output  1  one-cycle pulse when results update.
REQ-015 SHALL have port busy  output  1  high in RUN.
REQ-016 SHALL have port error  output  1  high in ERROR.

Function
REQ-017 SHALL implement states IDLE, RUN and ERROR.
REQ-018 IDLE: go&~finish -> RUN, load running max and min with data_in, running count = 1; go&finish or ~go&finish -> ERROR; otherwise stay.
REQ-019 RUN, ~finish: each cycle with data_valid=1, the update SHALL be max=max(max,data_in), min=min(min,data_in), count+1; data_valid=0 SHALL hold all values.
REQ-020 RUN, finish: SHALL include data_in if data_valid=1, register range/max_out/min_out/count from the final values, pulse done next cycle, and go to IDLE.
REQ-021 RUN: go SHALL be allowed to stay high continuously from the start cycle; a 0->1 go transition while in RUN with finish=0 SHALL go to ERROR and discard the running values.
REQ-022 RUN: a go rising edge and finish in the same cycle SHALL be treated as finish, per REQ-020.
REQ-023 ERROR: go&~finish SHALL start a new sequence, same as from IDLE; every other input combination SHALL stay in ERROR (sticky).
REQ-024 Compares SHALL be signed when SIGNED_MODE=1 and unsigned otherwise; range SHALL be max-min computed modulo 2^WIDTH, which is always exact as an unsigned value.
REQ-025 Count SHALL saturate at 2^CNT_WIDTH-1, with no wrap.
REQ-026 Result outputs SHALL hold their value until the next completed sequence; ERROR and aborted sequences SHALL leave them unchanged.
REQ-027 Latency from the finish cycle to the outputs being valid and done=1 SHALL be 1 clock.

Reset
REQ-028 reset SHALL force the state to IDLE and set range, max_out, min_out, count, done, busy and error to 0 immediately, including in mid-sequence.
REQ-029 The first rising clock edge after reset deasserts SHALL evaluate the IDLE transitions.

Configuration
REQ-030 With macro RANGE_STATS_COUNT_EN defined, the counter SHALL be built and count SHALL behave per REQ-019/REQ-025.
REQ-031 Without RANGE_STATS_COUNT_EN, the counter logic SHALL be absent, the count port SHALL remain and be tied to 0, and all other behaviour SHALL be unchanged.

Structure
REQ-032 Package range_stats_pkg SHALL hold the state enum typedef (IDLE, RUN, ERROR) and the 2-bit state width constant.
REQ-033 Sub-module minmax_update (parameters WIDTH and SIGNED_MODE; inputs sample, cur_max, cur_min, load; outputs new_max, new_min) SHALL hold all comparison logic.
REQ-034 The FSM, registers and counter SHALL live in stream_range_stats.

Verification
REQ-035 The bench SHALL cover: unsigned, go with 20, valid samples 5, 200, 90, then finish with 7 valid -> next cycle max_out=200, min_out=5, range=195, count=5, done one cycle.
REQ-036 The bench SHALL cover: SIGNED_MODE=1, WIDTH=8, samples 0x80(-128), 0x7F(127), 0x00 -> max_out=0x7F, min_out=0x80, range=255.
REQ-037 The bench SHALL cover: finish in IDLE -> error=1 next cycle, results unchanged; go&~finish later -> error=0, busy=1.
REQ-038 The bench SHALL cover: in RUN, go dropped then re-asserted with finish=0 -> ERROR; a later finish leaves the prior results intact.
REQ-039 The bench SHALL cover: CNT_WIDTH=3 with 10 valid samples -> count=7; without RANGE_STATS_COUNT_EN -> count=0.
REQ-040 The bench SHALL cover: reset asserted in the middle of RUN -> all outputs 0 without a clock edge; the next go starts a clean sequence.
